cnn_tile_streamer: RTL and testbench
====================================

// Module: cnn_tile_streamer
// PURPOSE
//  Synthesizable replacement for testbench-side preloading of image/weight buffers.
//  Reads NUM_CH on-chip RAMs in lockstep (ch0 = image, ch1 = weight, ...) from per-channel
//  base addresses for LEN words, with optional byte-order swap.
//  Delivers one packed beat per cycle to the MAC array over a valid/ready stream.
//  Sits between the buffer RAMs and the convolution datapath.
// PARAMETERS
//  DATA_W  16  word width per channel; multiple of 8
//  ADDR_W  20  RAM address width (1M words)
//  NUM_CH  2   channels read in lockstep
//  LEN_W   21  transfer length width; LEN up to 2^ADDR_W inclusive
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  start      in   1              launch transfer; sampled only in IDLE
//  base_addr  in   NUM_CH*ADDR_W  per-channel start address; ch i at [i*ADDR_W +: ADDR_W]
//  len        in   LEN_W          words per channel
//  swap_en    in   1              1 = reverse byte order of every word
//  busy       out  1              high from accepted start until done
//  done       out  1              one-cycle pulse at end of transfer
//  ram_rd_en  out  1              read strobe, common to all channels
//  ram_addr   out  NUM_CH*ADDR_W  per-channel read address
//  ram_rdata  in   NUM_CH*DATA_W  read data, valid exactly 1 cycle after ram_rd_en
//  out_valid  out  1              beat available
//  out_ready  in   1              consumer accepts beat when valid & ready
//  out_data   out  NUM_CH*DATA_W  packed beat; ch i at [i*DATA_W +: DATA_W]
//  out_last   out  1              marks the final beat, with out_valid
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to IDLE; FIFO and counters cleared.
//  - rst mid-transfer aborts immediately: no done pulse. The in-flight read is discarded.
//  - FSM IDLE -> RUN on start & len!=0.
//    - Latch base_addr, len and swap_en.
//    - busy rises next cycle.
//  - start & len==0 in IDLE: no reads, no beats; done pulses the next cycle; busy stays 0.
//  - start while busy is ignored. Latched inputs are stable for the whole transfer.
//  - RUN: issue a read when issued<len and (fifo_count + inflight) < 2.
//    - Address of ch i = base_i + issued, wrapping modulo 2^ADDR_W.
//  - Once issued==len, RUN -> DRAIN.
//  - DRAIN -> IDLE on the handshake of the last beat; done pulses that same cycle.
//    - busy drops the cycle after.
//  - Data path: ram_rdata, byte-swapped if latched swap_en, is written into a 2-entry FIFO.
//    - Swap per channel: byte k -> byte (DATA_W/8-1-k); 16-bit: {d[7:0],d[15:8]}.
//    - The FIFO drives out_* directly.
//  - Throughput and latency:
//    - With out_ready held high: 1 beat/cycle sustained.
//    - First out_valid 2 cycles after start.
//    - Each beat is held stable while valid & !ready. Never dropped or duplicated.
//  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
//  - out_last is high only on beat number len-1. Beats are emitted in address order.
// STRUCTURE
//  - cnn_pkg: FSM state encoding (IDLE/RUN/DRAIN); byte_swap(DATA_W) function;
//    default width constants.
//  - Sub-module cnn_skid_fifo: 2-deep register FIFO (WIDTH = NUM_CH*DATA_W+1 incl. last)
//    with full/empty/count.
//  - Top level holds the FSM, issue counter, inflight flag, beat counter and address adders.
// TESTING
//  1. len=4, base={0x10,0x0}, swap=0, ready=1 -> beats ram[0x10..0x13]/ram[0..3]
//     on 4 consecutive cycles. Last on beat 3; done with beat 3.
//  2. swap_en=1, word 0x1234 -> out 0x3412 in that channel; swap_en=0 -> 0x1234 unchanged.
//  3. len=8, out_ready toggling 1,0,0,1,... -> all 8 beats in order, held stable while stalled.
//     ram_rd_en never raised with FIFO+inflight=2.
//  4. base=0xFFFFE, len=4 -> addresses 0xFFFFE,0xFFFFF,0x00000,0x00001.
//  5. start with len=0 -> done 1 cycle later; no ram_rd_en, no out_valid.
//     start pulsed while busy -> ignored, counts unchanged.
//  6. rst asserted on beat 3 of len=16 -> next cycle all outputs 0, no done.
//     New start with len=2 completes normally.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN tile streamer.
//   state_t   : streamer FSM states (IDLE / RUN / DRAIN)
//   byte_swap : reverses the byte order of the low i_dataW bits of a word
//   DEF_*     : default width constants used by the top level
package cnn_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 20;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_LEN_W  = 21;

  // Widest word byte_swap can handle; callers zero-extend into this width.
  localparam int BSW_MAX_W  = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Byte k of the input lands in byte (nBytes-1-k) of the result; bits above
  // i_dataW come back as zero.
  function automatic logic [BSW_MAX_W-1:0] byte_swap(input logic [BSW_MAX_W-1:0] i_word,
                                                     input int i_dataW);
    logic [BSW_MAX_W-1:0] w_res;
    int nBytes;
    w_res  = '0;
    nBytes = i_dataW / 8;
    for (int k = 0; k < BSW_MAX_W / 8; k++) begin
      if (k < nBytes) begin
        w_res[8*(nBytes-1-k) +: 8] = i_word[8*k +: 8];
      end
    end
    return w_res;
  endfunction

endpackage

// File: rtl/cnn_skid_fifo.sv
// Two-entry register FIFO sitting between the RAM read data and the output
// stream. The head entry drives o_rdata directly.
//   i_clk, i_rst       : clock, synchronous active-high reset (clears contents)
//   i_push, i_wdata    : write strobe and data
//   i_pop              : remove head entry (ignored when empty)
//   o_rdata            : head entry
//   o_empty, o_full    : status flags
//   o_count            : number of stored entries (0..2)
module cnn_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign w_doPop  = i_pop && (r_count != 2'd0);
  assign w_doPush = i_push && ((r_count != 2'd2) || w_doPop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_wdata;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_doPop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rdPtr];
  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_count = r_count;

endmodule

// File: rtl/cnn_tile_streamer.sv
// Streams LEN words from NUM_CH buffer RAMs, read in lockstep, to the MAC
// array as one packed beat per cycle over a valid/ready interface.
//   i_clk, i_rst    : clock, synchronous active-high reset (aborts a transfer)
//   i_start         : launch a transfer (sampled only while idle)
//   i_base_addr     : per-channel start address, ch i at [i*ADDR_W +: ADDR_W]
//   i_len           : words per channel (0 = immediate done, no reads)
//   i_swap_en       : reverse byte order of every word
//   o_busy, o_done  : transfer in progress / one-cycle completion pulse
//   o_ram_rd_en     : common read strobe; o_ram_addr per-channel address
//   i_ram_rdata     : read data, valid one cycle after o_ram_rd_en
//   o_out_*         : output beat stream, o_out_last marks beat len-1
module cnn_tile_streamer
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [NUM_CH*ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]         i_len,
  input  logic                     i_swap_en,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_ram_rd_en,
  output logic [NUM_CH*ADDR_W-1:0] o_ram_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_ram_rdata,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [NUM_CH*DATA_W-1:0] o_out_data,
  output logic                     o_out_last
);

  localparam int BEAT_W = NUM_CH * DATA_W;

  state_t                   r_state;
  state_t                   w_stateNext;
  logic [NUM_CH*ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_issued;
  logic [LEN_W-1:0]         r_beatCnt;
  logic                     r_swap;
  logic                     r_inflight;
  logic                     r_inflightLast;
  logic                     r_zeroDone;

  logic                     w_startGo;
  logic                     w_startZero;
  logic                     w_issue;
  logic                     w_issueLast;
  logic                     w_pop;
  logic                     w_lastPop;
  logic                     w_room;
  logic [2:0]               w_occ;
  logic [LEN_W-1:0]         w_lenSel;
  logic [LEN_W-1:0]         w_issuedSel;
  logic [NUM_CH*ADDR_W-1:0] w_baseSel;
  logic [BEAT_W-1:0]        w_pushData;
  logic [DATA_W-1:0]        w_word;
  logic [BSW_MAX_W-1:0]     w_wide;
  logic [BSW_MAX_W-1:0]     w_swapped;
  logic [BEAT_W:0]          w_fifoOut;
  logic                     w_fifoEmpty;
  logic                     w_fifoFull;
  logic [1:0]               w_fifoCount;

  assign w_startGo   = (r_state == ST_IDLE) && i_start && (i_len != '0) && !i_rst;
  assign w_startZero = (r_state == ST_IDLE) && i_start && (i_len == '0) && !i_rst;
  assign w_pop       = !w_fifoEmpty && i_out_ready;

  // The first read goes out in the start cycle itself, straight from the
  // live inputs, so the first beat is valid two cycles after start.
  assign w_baseSel   = (r_state == ST_IDLE) ? i_base_addr : r_base;
  assign w_lenSel    = (r_state == ST_IDLE) ? i_len : r_len;
  assign w_issuedSel = (r_state == ST_IDLE) ? '0 : r_issued;
  assign w_issueLast = ((w_issuedSel + LEN_W'(1)) == w_lenSel);

  // Occupancy counts the read in flight; a beat leaving this cycle frees its
  // slot immediately, which is what sustains one beat per cycle.
  assign w_occ  = {1'b0, w_fifoCount} + {2'b00, r_inflight};
  assign w_room = w_fifoFull ? w_pop : ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_issue     = 1'b0;
    w_lastPop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_startGo) begin
          w_issue     = 1'b1;
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_issued == r_len) begin
          w_stateNext = ST_DRAIN;
        end else if (w_room) begin
          w_issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_stateNext = ST_DRAIN;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
    if ((r_state != ST_IDLE) && w_pop && (r_beatCnt == (r_len - LEN_W'(1)))) begin
      w_lastPop   = 1'b1;
      w_stateNext = ST_IDLE;
    end
    o_ram_rd_en = w_issue && !i_rst;
    o_done      = !i_rst && (w_lastPop || r_zeroDone);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base         <= '0;
      r_len          <= '0;
      r_swap         <= 1'b0;
      r_issued       <= '0;
      r_beatCnt      <= '0;
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
      r_zeroDone     <= 1'b0;
    end else begin
      r_inflight     <= w_issue;
      r_inflightLast <= w_issue && w_issueLast;
      r_zeroDone     <= w_startZero;
      if (w_startGo) begin
        r_base    <= i_base_addr;
        r_len     <= i_len;
        r_swap    <= i_swap_en;
        r_issued  <= LEN_W'(1);
        r_beatCnt <= '0;
      end else begin
        if (w_issue) begin
          r_issued <= r_issued + LEN_W'(1);
        end
        if (w_pop) begin
          r_beatCnt <= r_beatCnt + LEN_W'(1);
        end
      end
    end
  end

  // Addresses wrap naturally modulo 2^ADDR_W; idle address lines read as zero.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_addr
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = w_baseSel[ch*ADDR_W +: ADDR_W] + w_issuedSel[ADDR_W-1:0];
    assign o_ram_addr[ch*ADDR_W +: ADDR_W] = o_ram_rd_en ? w_addr : '0;
  end

  // Returning data uses the swap setting latched at start.
  always_comb begin
    w_pushData = '0;
    w_word     = '0;
    w_wide     = '0;
    w_swapped  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_word                 = i_ram_rdata[ch*DATA_W +: DATA_W];
      w_wide                 = '0;
      w_wide[DATA_W-1:0]     = w_word;
      w_swapped              = byte_swap(w_wide, DATA_W);
      w_pushData[ch*DATA_W +: DATA_W] = r_swap ? w_swapped[DATA_W-1:0] : w_word;
    end
  end

  cnn_skid_fifo #(
    .WIDTH(BEAT_W + 1)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (r_inflight),
    .i_wdata({r_inflightLast, w_pushData}),
    .i_pop  (i_out_ready),
    .o_rdata(w_fifoOut),
    .o_empty(w_fifoEmpty),
    .o_full (w_fifoFull),
    .o_count(w_fifoCount)
  );

  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_valid = !w_fifoEmpty;
  assign o_out_data  = w_fifoOut[BEAT_W-1:0];
  assign o_out_last  = w_fifoOut[BEAT_W] && !w_fifoEmpty;

endmodule

// File: tb/tb_cnn_tile_streamer.sv
// Self-checking bench for cnn_tile_streamer: a behavioural RAM plus a
// reference model that predicts beats and addresses from base + index.
module tb_cnn_tile_streamer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 20;
  localparam int NUM_CH = 2;
  localparam int LEN_W  = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [39:0] baseAddr;
  logic [20:0] lenIn;
  logic        swapEn;
  logic        busy;
  logic        done;
  logic        ramRdEn;
  logic [39:0] ramAddr;
  logic [31:0] ramRdata;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic        outLast;

  int vectors = 0;
  int miscompares = 0;
  bit patMode = 1'b0;

  logic [31:0] gotData[$];
  bit          gotLast[$];
  logic [39:0] gotAddr[$];
  int firstValid, doneCyc, doneCnt, lastHsCyc, overflowErr, stallErr, busyErr;

  always #5 clk = ~clk;

  cnn_tile_streamer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .LEN_W(LEN_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(baseAddr),
    .i_len(lenIn), .i_swap_en(swapEn), .o_busy(busy), .o_done(done),
    .o_ram_rd_en(ramRdEn), .o_ram_addr(ramAddr), .i_ram_rdata(ramRdata),
    .o_out_valid(outValid), .i_out_ready(outReady), .o_out_data(outData),
    .o_out_last(outLast)
  );

  function automatic logic [15:0] ramWord(input int ch, input logic [19:0] a);
    if (patMode) return (ch == 0) ? 16'h1234 : 16'hBEEF;
    return a[15:0] ^ {a[19:16], 12'h000} ^ ((ch == 1) ? 16'h5A3C : 16'h0000);
  endfunction

  function automatic logic [15:0] swap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  // Reference: beat j is word (base + j) of each channel, optionally swapped.
  function automatic logic [31:0] expBeat(input logic [19:0] b0, input logic [19:0] b1,
                                          input bit sw, input int j);
    logic [19:0] a0, a1;
    logic [15:0] d0, d1;
    a0 = b0 + 20'(j);
    a1 = b1 + 20'(j);
    d0 = ramWord(0, a0);
    d1 = ramWord(1, a1);
    return sw ? {swap16(d1), swap16(d0)} : {d1, d0};
  endfunction

  function automatic logic [39:0] expAddr(input logic [19:0] b0, input logic [19:0] b1, input int j);
    logic [19:0] a0, a1;
    a0 = b0 + 20'(j);
    a1 = b1 + 20'(j);
    return {a1, a0};
  endfunction

  // RAM with one-cycle read latency; garbage when not read.
  always @(posedge clk) begin
    if (ramRdEn) ramRdata <= {ramWord(1, ramAddr[39:20]), ramWord(0, ramAddr[19:0])};
    else         ramRdata <= $urandom;
  end

  // Drives one transfer and records what the DUT does at its ports.
  // readyMode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  task automatic applyStimulus(input logic [19:0] b0, input logic [19:0] b1, input int len,
                               input bit sw, input int readyMode, input int glitchCyc);
    int issued, accepted, budget, pop, expBusy;
    bit prevStall;
    logic [32:0] prevBeat;
    issued = 0; accepted = 0; prevStall = 1'b0; prevBeat = '0;
    gotData.delete(); gotLast.delete(); gotAddr.delete();
    firstValid = -1; doneCyc = -1; doneCnt = 0; lastHsCyc = -1;
    overflowErr = 0; stallErr = 0; busyErr = 0;
    budget = 4 * len + 30;
    @(negedge clk);
    start = 1'b1; baseAddr = {b1, b0}; lenIn = 21'(len); swapEn = sw;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) begin
        start    = (cyc == glitchCyc);
        baseAddr = {$urandom, $urandom};
        lenIn    = 21'($urandom_range(1, 50));
        swapEn   = 1'($urandom);
      end
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = ((cyc % 3) == 0);
        default: outReady = 1'($urandom_range(0, 1));
      endcase
      #1;
      expBusy = (cyc == 0 || len == 0 || doneCyc >= 0) ? 0 : 1;
      if (int'(busy) != expBusy) busyErr++;
      pop = (outValid && outReady) ? 1 : 0;
      if (ramRdEn) begin
        if ((issued - accepted - pop) >= 2) overflowErr++;
        gotAddr.push_back(ramAddr);
        issued++;
      end
      if (prevStall && (!outValid || {outLast, outData} !== prevBeat)) stallErr++;
      if (outValid && firstValid < 0) firstValid = cyc;
      if (pop == 1) begin
        gotData.push_back(outData);
        gotLast.push_back(outLast);
        accepted++;
        lastHsCyc = cyc;
      end
      if (done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      prevStall = outValid && !outReady;
      prevBeat  = {outLast, outData};
      @(posedge clk);
      @(negedge clk);
      if (doneCyc >= 0 && cyc >= doneCyc + 2) break;
    end
    start = 1'b0;
    outReady = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; baseAddr = '0; lenIn = '0; swapEn = 1'b0; outReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy, done, ramRdEn, outValid, outLast} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b want 00000", {busy, done, ramRdEn, outValid, outLast});
    end
    vectors++;
    if ({ramAddr, outData} !== 72'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_buses got %h/%h want 0", ramAddr, outData);
    end
  endtask

  task automatic test_basic();
    applyStimulus(20'h00010, 20'h00000, 4, 1'b0, 0, -1);
    vectors++;
    if (gotData.size() != 4) begin
      miscompares++; $display("[TB] FAIL basic_count got %0d want 4", gotData.size());
    end
    for (int j = 0; j < gotData.size() && j < 4; j++) begin
      vectors++;
      if (gotData[j] !== expBeat(20'h00010, 20'h00000, 1'b0, j)) begin
        miscompares++;
        $display("[TB] FAIL basic_beat%0d got %h want %h", j, gotData[j], expBeat(20'h00010, 20'h00000, 1'b0, j));
      end
      vectors++;
      if (gotLast[j] !== (j == 3)) begin
        miscompares++; $display("[TB] FAIL basic_last%0d got %b want %b", j, gotLast[j], (j == 3));
      end
    end
    vectors++;
    if (firstValid != 2) begin
      miscompares++; $display("[TB] FAIL basic_latency got %0d want 2", firstValid);
    end
    vectors++;
    if (lastHsCyc != 5 || doneCyc != 5 || doneCnt != 1) begin
      miscompares++;
      $display("[TB] FAIL basic_done got last=%0d done=%0d cnt=%0d want 5/5/1", lastHsCyc, doneCyc, doneCnt);
    end
    vectors++;
    if (busyErr != 0) begin
      miscompares++; $display("[TB] FAIL basic_busy got %0d errors want 0", busyErr);
    end
  endtask

  task automatic test_swap();
    patMode = 1'b1;
    for (int s = 0; s < 2; s++) begin
      applyStimulus(20'h00100, 20'h00200, 3, 1'(s), 0, -1);
      vectors++;
      if (gotData.size() != 3 || doneCnt != 1) begin
        miscompares++; $display("[TB] FAIL swap%0d_count got %0d/%0d want 3/1", s, gotData.size(), doneCnt);
      end
      for (int j = 0; j < gotData.size(); j++) begin
        vectors++;
        if (gotData[j] !== ((s == 1) ? 32'hEFBE_3412 : 32'hBEEF_1234)) begin
          miscompares++;
          $display("[TB] FAIL swap%0d_beat%0d got %h want %h", s, j, gotData[j], (s == 1) ? 32'hEFBE_3412 : 32'hBEEF_1234);
        end
      end
    end
    patMode = 1'b0;
  endtask

  task automatic test_backpressure();
    applyStimulus(20'h01234, 20'h54321, 8, 1'b1, 1, -1);
    vectors++;
    if (gotData.size() != 8 || doneCnt != 1) begin
      miscompares++; $display("[TB] FAIL bp_count got %0d/%0d want 8/1", gotData.size(), doneCnt);
    end
    for (int j = 0; j < gotData.size() && j < 8; j++) begin
      vectors++;
      if (gotData[j] !== expBeat(20'h01234, 20'h54321, 1'b1, j) || gotLast[j] !== (j == 7)) begin
        miscompares++;
        $display("[TB] FAIL bp_beat%0d got %h/%b want %h/%b", j, gotData[j], gotLast[j],
                 expBeat(20'h01234, 20'h54321, 1'b1, j), (j == 7));
      end
    end
    vectors++;
    if (stallErr != 0 || overflowErr != 0) begin
      miscompares++; $display("[TB] FAIL bp_flow got stall=%0d overflow=%0d want 0/0", stallErr, overflowErr);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(20'hFFFFE, 20'h7FFFF, 4, 1'b0, 0, -1);
    vectors++;
    if (gotAddr.size() != 4) begin
      miscompares++; $display("[TB] FAIL wrap_reads got %0d want 4", gotAddr.size());
    end
    for (int j = 0; j < gotAddr.size() && j < 4; j++) begin
      vectors++;
      if (gotAddr[j] !== expAddr(20'hFFFFE, 20'h7FFFF, j)) begin
        miscompares++;
        $display("[TB] FAIL wrap_addr%0d got %h want %h", j, gotAddr[j], expAddr(20'hFFFFE, 20'h7FFFF, j));
      end
    end
    for (int j = 0; j < gotData.size() && j < 4; j++) begin
      vectors++;
      if (gotData[j] !== expBeat(20'hFFFFE, 20'h7FFFF, 1'b0, j)) begin
        miscompares++;
        $display("[TB] FAIL wrap_beat%0d got %h want %h", j, gotData[j], expBeat(20'hFFFFE, 20'h7FFFF, 1'b0, j));
      end
    end
  endtask

  task automatic test_zero_len_and_restart();
    applyStimulus(20'h00040, 20'h00080, 0, 1'b0, 0, -1);
    vectors++;
    if (doneCyc != 1 || doneCnt != 1) begin
      miscompares++; $display("[TB] FAIL zero_done got cyc=%0d cnt=%0d want 1/1", doneCyc, doneCnt);
    end
    vectors++;
    if (gotAddr.size() != 0 || firstValid != -1 || busyErr != 0) begin
      miscompares++;
      $display("[TB] FAIL zero_quiet got reads=%0d valid@%0d busyErr=%0d want 0/-1/0", gotAddr.size(), firstValid, busyErr);
    end
    applyStimulus(20'h00300, 20'h00500, 8, 1'b0, 0, 3);
    vectors++;
    if (gotData.size() != 8 || gotAddr.size() != 8 || doneCnt != 1) begin
      miscompares++;
      $display("[TB] FAIL restart_count got %0d/%0d/%0d want 8/8/1", gotData.size(), gotAddr.size(), doneCnt);
    end
    for (int j = 0; j < gotData.size() && j < 8; j++) begin
      vectors++;
      if (gotData[j] !== expBeat(20'h00300, 20'h00500, 1'b0, j)) begin
        miscompares++;
        $display("[TB] FAIL restart_beat%0d got %h want %h", j, gotData[j], expBeat(20'h00300, 20'h00500, 1'b0, j));
      end
    end
  endtask

  task automatic test_reset_abort();
    int accepted;
    bit reached;
    accepted = 0; reached = 1'b0;
    @(negedge clk);
    start = 1'b1; baseAddr = {20'h00900, 20'h00A00}; lenIn = 21'd16; swapEn = 1'b0; outReady = 1'b1;
    for (int cyc = 0; cyc < 40 && !reached; cyc++) begin
      #1;
      if (outValid && accepted == 3) begin
        reached = 1'b1;
        rst = 1'b1;
        #1;
        vectors++;
        if (done !== 1'b0) begin
          miscompares++; $display("[TB] FAIL abort_done_in_rst got %b want 0", done);
        end
      end else if (outValid && outReady) begin
        accepted++;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    vectors++;
    if (!reached) begin
      miscompares++; $display("[TB] FAIL abort_reach got %0d beats want 3 before timeout", accepted);
    end
    #1;
    vectors++;
    if ({busy, done, ramRdEn, outValid, outLast} !== 5'b0 || {ramAddr, outData} !== 72'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_outputs got %b %h %h want all 0", {busy, done, ramRdEn, outValid, outLast}, ramAddr, outData);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (done !== 1'b0 || outValid !== 1'b0) begin
        miscompares++; $display("[TB] FAIL abort_quiet%0d got done=%b valid=%b want 0/0", k, done, outValid);
      end
    end
    applyStimulus(20'h00042, 20'h00024, 2, 1'b1, 0, -1);
    vectors++;
    if (gotData.size() != 2 || doneCnt != 1) begin
      miscompares++; $display("[TB] FAIL abort_next_count got %0d/%0d want 2/1", gotData.size(), doneCnt);
    end
    for (int j = 0; j < gotData.size() && j < 2; j++) begin
      vectors++;
      if (gotData[j] !== expBeat(20'h00042, 20'h00024, 1'b1, j) || gotLast[j] !== (j == 1)) begin
        miscompares++;
        $display("[TB] FAIL abort_next_beat%0d got %h/%b want %h/%b", j, gotData[j], gotLast[j],
                 expBeat(20'h00042, 20'h00024, 1'b1, j), (j == 1));
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] b0, b1;
    int len;
    bit sw;
    for (int it = 0; it < 8; it++) begin
      b0  = (it % 2 == 0) ? 20'($urandom) : 20'hFFFF0 + 20'($urandom_range(0, 15));
      b1  = 20'($urandom);
      len = $urandom_range(1, 24);
      sw  = 1'($urandom);
      applyStimulus(b0, b1, len, sw, 2, $urandom_range(2, 10));
      vectors++;
      if (gotData.size() != len || gotAddr.size() != len || doneCnt != 1) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_count got %0d/%0d/%0d want %0d/%0d/1", it, gotData.size(), gotAddr.size(), doneCnt, len, len);
      end
      vectors++;
      if (stallErr != 0 || overflowErr != 0 || busyErr != 0 || doneCyc != lastHsCyc) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_flow got stall=%0d ovf=%0d busy=%0d done@%0d last@%0d want 0/0/0 and equal",
                 it, stallErr, overflowErr, busyErr, doneCyc, lastHsCyc);
      end
      for (int j = 0; j < gotData.size() && j < len; j++) begin
        vectors++;
        if (gotData[j] !== expBeat(b0, b1, sw, j) || gotLast[j] !== (j == len - 1)) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_beat%0d got %h/%b want %h/%b", it, j, gotData[j], gotLast[j],
                   expBeat(b0, b1, sw, j), (j == len - 1));
        end
      end
      for (int j = 0; j < gotAddr.size() && j < len; j++) begin
        vectors++;
        if (gotAddr[j] !== expAddr(b0, b1, j)) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_addr%0d got %h want %h", it, j, gotAddr[j], expAddr(b0, b1, j));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_backpressure();
    test_wrap();
    test_zero_len_and_restart();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
